genius_seq_ctrl: RTL and testbench

Parametrised Genius (Simon) game controller. It stores a growing colour sequence of up to MAX_LEN entries and replays it with internal display and gap timers. It then checks the player's button presses against the sequence under an internal timeout and reports win or loss. It sits between the button decoder, which supplies BTN_VALID/BTN_COLOR, the random-colour source RND, and the VGA colour renderer, which consumes SHOW_VALID/SHOW_COLOR, WIN and LOSE.

---
 rtl/genius_seq_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_genius_seq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/genius_seq_ctrl.sv
// genius_seq_ctrl
//   Genius (Simon) game controller. Grows a random colour sequence one entry
//   per round, replays it with show/gap timing, then checks each player press
//   against the stored sequence under a per-press timeout.
//
// Ports
//   CLK         in   system clock, rising edge
//   RESET       in   asynchronous active-high reset
//   START       in   start/restart request, honoured only in IDLE/WON/LOST
//   BTN_VALID   in   one-cycle press strobe (only looked at in WAIT_IN)
//   BTN_COLOR   in   colour of the press
//   RND         in   random colour, appended to the sequence in APPEND
//   SHOW_VALID  out  a colour is being displayed (replay or echo)
//   SHOW_COLOR  out  displayed colour, 0 when dark
//   LEVEL       out  current sequence length / score
//   WIN, LOSE   out  high while in WON / LOST
//   STATE       out  state encoding for debug
module genius_seq_ctrl #(
    parameter int MAX_LEN   = 16,
    parameter int CW        = 2,
    parameter int SHOW_CYC  = 25_000_000,
    parameter int GAP_CYC   = 5_000_000,
    parameter int INPUT_CYC = 100_000_000,
    localparam int LW       = $clog2(MAX_LEN + 1)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          START,
    input  logic          BTN_VALID,
    input  logic [CW-1:0] BTN_COLOR,
    input  logic [CW-1:0] RND,
    output logic          SHOW_VALID,
    output logic [CW-1:0] SHOW_COLOR,
    output logic [LW-1:0] LEVEL,
    output logic          WIN,
    output logic          LOSE,
    output logic [2:0]    STATE
);

    localparam int MAX_SG = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
    localparam int MAX_T  = (MAX_SG > INPUT_CYC) ? MAX_SG : INPUT_CYC;
    // The timer only ever holds values 0..MAX_T-1.
    localparam int TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int IW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [TW-1:0] T_SHOW  = TW'(SHOW_CYC - 1);
    localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] T_INPUT = TW'(INPUT_CYC - 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_APPEND   = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_GAP = 3'd3,
        S_WAIT_IN  = 3'd4,
        S_ECHO     = 3'd5,
        S_WON      = 3'd6,
        S_LOST     = 3'd7
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_seq [MAX_LEN];
    logic [LW-1:0] r_level;
    logic [LW-1:0] r_idx;
    logic [TW-1:0] r_t;
    logic          r_show_valid;
    logic [CW-1:0] r_show_color;
    logic          r_win;
    logic          r_lose;

    logic          w_t_zero;
    logic          w_last;
    logic [CW-1:0] w_expect;
    logic [CW-1:0] w_first_color;
    logic [CW-1:0] w_next_color;

    assign w_t_zero     = (r_t == '0);
    assign w_last       = (r_idx == r_level - LW'(1));
    assign w_expect     = r_seq[r_idx[IW-1:0]];
    assign w_next_color = r_seq[r_idx[IW-1:0] + IW'(1)];
    // SHOW_COLOR is registered, so the first replayed colour is loaded on the
    // APPEND edge; in round one SEQ[0] is being written on that same edge.
    assign w_first_color = (r_level == '0) ? RND : r_seq[0];

    // Sequence storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (r_state == S_APPEND) begin
            r_seq[r_level[IW-1:0]] <= RND;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_level      <= '0;
            r_idx        <= '0;
            r_t          <= '0;
            r_show_valid <= 1'b0;
            r_show_color <= '0;
            r_win        <= 1'b0;
            r_lose       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_WON, S_LOST: begin
                    if (START) begin
                        r_level <= '0;
                        r_win   <= 1'b0;
                        r_lose  <= 1'b0;
                        r_state <= S_APPEND;
                    end
                end

                S_APPEND: begin
                    r_level      <= r_level + LW'(1);
                    r_idx        <= '0;
                    r_t          <= T_SHOW;
                    r_show_valid <= 1'b1;
                    r_show_color <= w_first_color;
                    r_state      <= S_SHOW_ON;
                end

                S_SHOW_ON: begin
                    if (w_t_zero) begin
                        r_t          <= T_GAP;
                        r_show_valid <= 1'b0;
                        r_show_color <= '0;
                        r_state      <= S_SHOW_GAP;
                    end else begin
                        r_t <= r_t - TW'(1);
                    end
                end

                S_SHOW_GAP: begin
                    if (w_t_zero) begin
                        if (w_last) begin
                            r_idx   <= '0;
                            r_t     <= T_INPUT;
                            r_state <= S_WAIT_IN;
                        end else begin
                            r_idx        <= r_idx + LW'(1);
                            r_t          <= T_SHOW;
                            r_show_valid <= 1'b1;
                            r_show_color <= w_next_color;
                            r_state      <= S_SHOW_ON;
                        end
                    end else begin
                        r_t <= r_t - TW'(1);
                    end
                end

                S_WAIT_IN: begin
                    // A press on the timeout cycle still counts.
                    if (BTN_VALID) begin
                        if (BTN_COLOR == w_expect) begin
                            r_t          <= T_SHOW;
                            r_show_valid <= 1'b1;
                            r_show_color <= BTN_COLOR;
                            r_state      <= S_ECHO;
                        end else begin
                            r_lose  <= 1'b1;
                            r_state <= S_LOST;
                        end
                    end else if (w_t_zero) begin
                        r_lose  <= 1'b1;
                        r_state <= S_LOST;
                    end else begin
                        r_t <= r_t - TW'(1);
                    end
                end

                S_ECHO: begin
                    if (w_t_zero) begin
                        r_show_valid <= 1'b0;
                        r_show_color <= '0;
                        if (w_last) begin
                            if (r_level == LEN_MAX) begin
                                r_win   <= 1'b1;
                                r_state <= S_WON;
                            end else begin
                                r_state <= S_APPEND;
                            end
                        end else begin
                            r_idx   <= r_idx + LW'(1);
                            r_t     <= T_INPUT;
                            r_state <= S_WAIT_IN;
                        end
                    end else begin
                        r_t <= r_t - TW'(1);
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign SHOW_VALID = r_show_valid;
    assign SHOW_COLOR = r_show_color;
    assign LEVEL      = r_level;
    assign WIN        = r_win;
    assign LOSE       = r_lose;
    assign STATE      = r_state;

endmodule

// File: tb/tb_genius_seq_ctrl.sv
// tb_genius_seq_ctrl
//   Bench for genius_seq_ctrl (MAX_LEN=4, CW=2, SHOW_CYC=3, GAP_CYC=2,
//   INPUT_CYC=10). A time-based game model predicts every output each cycle;
//   directed scenarios with literal expectations precede a random phase.
module tb_genius_seq_ctrl;

    localparam int ML = 4;
    localparam int S  = 3;
    localparam int G  = 2;
    localparam int I  = 10;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       BTN_VALID = 1'b0;
    logic [1:0] BTN_COLOR = '0;
    logic [1:0] RND = '0;
    logic       SHOW_VALID;
    logic [1:0] SHOW_COLOR;
    logic [2:0] LEVEL;
    logic       WIN;
    logic       LOSE;
    logic [2:0] STATE;

    genius_seq_ctrl #(
        .MAX_LEN(ML), .CW(2), .SHOW_CYC(S), .GAP_CYC(G), .INPUT_CYC(I)
    ) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .BTN_VALID(BTN_VALID),
        .BTN_COLOR(BTN_COLOR), .RND(RND), .SHOW_VALID(SHOW_VALID),
        .SHOW_COLOR(SHOW_COLOR), .LEVEL(LEVEL), .WIN(WIN), .LOSE(LOSE),
        .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game model: phases with a start cycle; outputs derive from elapsed time.
    typedef enum int {M_IDLE, M_APPEND, M_PLAY, M_WAIT, M_ECHO, M_WON, M_LOST} mmode_t;
    mmode_t mmode = M_IDLE;
    int cyc = 0;
    int t0 = 0;
    int mlevel = 0;
    int mpos = 0;
    int ecol = 0;
    int mseq [ML];

    always @(posedge CLK) begin
        int e, st, sv, col;
        cyc++;
        if (RESET) begin
            mmode  = M_IDLE;
            mlevel = 0;
        end else begin
            case (mmode)
                M_IDLE, M_WON, M_LOST:
                    if (START) begin mmode = M_APPEND; mlevel = 0; end
                M_APPEND: begin
                    mseq[mlevel] = int'(RND);
                    mlevel++;
                    mmode = M_PLAY;
                    t0 = cyc;
                end
                M_PLAY:
                    if (cyc - t0 == mlevel * (S + G)) begin
                        mmode = M_WAIT; t0 = cyc; mpos = 0;
                    end
                M_WAIT:
                    if (BTN_VALID) begin
                        if (int'(BTN_COLOR) == mseq[mpos]) begin
                            mmode = M_ECHO; ecol = int'(BTN_COLOR); t0 = cyc;
                        end else begin
                            mmode = M_LOST;
                        end
                    end else if (cyc - t0 == I) begin
                        mmode = M_LOST;
                    end
                M_ECHO:
                    if (cyc - t0 == S) begin
                        if (mpos == mlevel - 1)
                            mmode = (mlevel == ML) ? M_WON : M_APPEND;
                        else begin
                            mpos++; mmode = M_WAIT; t0 = cyc;
                        end
                    end
                default: mmode = M_IDLE;
            endcase
        end

        sv = 0; col = 0; st = 0;
        case (mmode)
            M_IDLE:   st = 0;
            M_APPEND: st = 1;
            M_PLAY: begin
                e = cyc - t0;
                if (e % (S + G) < S) begin
                    st = 2; sv = 1; col = mseq[e / (S + G)];
                end else st = 3;
            end
            M_WAIT:   st = 4;
            M_ECHO:   begin st = 5; sv = 1; col = ecol; end
            M_WON:    st = 6;
            default:  st = 7;
        endcase

        #1;
        check("STATE", int'(STATE), st);
        check("SHOW_VALID", int'(SHOW_VALID), sv);
        check("SHOW_COLOR", int'(SHOW_COLOR), col);
        check("LEVEL", int'(LEVEL), mlevel);
        check("WIN", int'(WIN), (mmode == M_WON) ? 1 : 0);
        check("LOSE", int'(LOSE), (mmode == M_LOST) ? 1 : 0);
    end

    // Waits (bounded) until STATE==s, counting displayed cycles on the way.
    task automatic wait_state(input int s, input int budget, output int nshow);
        int n;
        n = 0;
        nshow = 0;
        do begin
            @(negedge CLK);
            n++;
            if (SHOW_VALID) nshow++;
        end while (int'(STATE) != s && n < budget);
        check("wait_state", int'(STATE), s);
    endtask

    int cols [4] = '{2, 1, 3, 0};

    initial begin
        int n;

        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_STATE", int'(STATE), 0);
        check("rst_LEVEL", int'(LEVEL), 0);
        check("rst_SV", int'(SHOW_VALID), 0);
        check("rst_WIN", int'(WIN), 0);
        check("rst_LOSE", int'(LOSE), 0);
        RESET = 1'b0;

        // Reset in the middle of SHOW_ON takes effect immediately
        @(negedge CLK); START = 1'b1; RND = 2'd3;
        @(negedge CLK); START = 1'b0;
        check("A_append", int'(STATE), 1);
        @(negedge CLK);
        check("A_show_on", int'(STATE), 2);
        RESET = 1'b1;
        #1;
        check("A_rst_STATE", int'(STATE), 0);
        check("A_rst_SV", int'(SHOW_VALID), 0);
        check("A_rst_COLOR", int'(SHOW_COLOR), 0);
        check("A_rst_LEVEL", int'(LEVEL), 0);
        @(negedge CLK); RESET = 1'b0;

        // First round, colour 2; presses and START during replay are ignored
        START = 1'b1; RND = 2'd2;
        @(negedge CLK); START = 1'b0;
        check("B_append", int'(STATE), 1);
        check("B_level0", int'(LEVEL), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            BTN_VALID = (i == 0); START = (i == 0); BTN_COLOR = 2'd1;
            check("B_show_sv", int'(SHOW_VALID), 1);
            check("B_show_col", int'(SHOW_COLOR), 2);
            check("B_level1", int'(LEVEL), 1);
        end
        BTN_VALID = 1'b0; START = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("B_gap_sv", int'(SHOW_VALID), 0);
            check("B_gap_state", int'(STATE), 3);
        end
        @(negedge CLK);
        check("B_wait", int'(STATE), 4);

        // Press on the very last WAIT_IN cycle is accepted
        repeat (9) @(negedge CLK);
        check("C_still_wait", int'(STATE), 4);
        BTN_VALID = 1'b1; BTN_COLOR = 2'd2; RND = 2'd1;
        @(negedge CLK); BTN_VALID = 1'b0;
        check("C_echo", int'(STATE), 5);
        check("C_echo_col", int'(SHOW_COLOR), 2);
        repeat (2) begin
            @(negedge CLK);
            check("C_echo_sv", int'(SHOW_VALID), 1);
        end
        @(negedge CLK);
        check("C_append", int'(STATE), 1);

        // Level 2 (2,1): correct then wrong press
        wait_state(4, 40, n);
        check("D_replay_show", n, 6);
        BTN_VALID = 1'b1; BTN_COLOR = 2'd2;
        @(negedge CLK); BTN_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge CLK);
            check("D_echo_state", int'(STATE), 5);
            check("D_echo_col", int'(SHOW_COLOR), 2);
        end
        @(negedge CLK);
        check("D_wait2", int'(STATE), 4);
        BTN_VALID = 1'b1; BTN_COLOR = 2'd3;
        @(negedge CLK); BTN_VALID = 1'b0;
        check("D_lose", int'(LOSE), 1);
        check("D_level", int'(LEVEL), 2);
        check("D_state", int'(STATE), 7);

        // Timeout: LOSE on the 11th WAIT_IN cycle
        START = 1'b1; RND = 2'd0;
        @(negedge CLK); START = 1'b0;
        wait_state(4, 40, n);
        check("E_replay_show", n, 3);
        repeat (9) @(negedge CLK);
        check("E_wait10", int'(STATE), 4);
        @(negedge CLK);
        check("E_lose", int'(LOSE), 1);
        check("E_state", int'(STATE), 7);

        // Full game 2,1,3,0
        for (int lvl = 0; lvl < 4; lvl++) begin
            RND = 2'(cols[lvl]);
            if (lvl == 0) begin
                START = 1'b1;
                @(negedge CLK); START = 1'b0;
            end
            wait_state(4, 200, n);
            check("F_replay_show", n, ((lvl > 0) ? 2 : 0) + 3 * (lvl + 1));
            for (int j = 0; j <= lvl; j++) begin
                BTN_VALID = 1'b1; BTN_COLOR = 2'(cols[j]);
                @(negedge CLK); BTN_VALID = 1'b0;
                if (j < lvl) wait_state(4, 20, n);
            end
        end
        wait_state(6, 20, n);
        check("F_win", int'(WIN), 1);
        check("F_level", int'(LEVEL), 4);
        START = 1'b1;
        @(negedge CLK); START = 1'b0;
        check("F_restart_state", int'(STATE), 1);
        check("F_restart_lvl0", int'(LEVEL), 0);
        @(negedge CLK);
        check("F_restart_lvl1", int'(LEVEL), 1);

        // Random play
        for (int k = 0; k < 5000; k++) begin
            @(negedge CLK);
            RND = 2'($urandom_range(0, 3));
            RESET = ($urandom_range(0, 799) == 0);
            if (mmode == M_IDLE || mmode == M_WON || mmode == M_LOST)
                START = ($urandom_range(0, 3) == 0);
            else
                START = ($urandom_range(0, 15) == 0);
            BTN_VALID = 1'b0;
            if (mmode == M_WAIT) begin
                if ($urandom_range(0, 3) == 0) begin
                    BTN_VALID = 1'b1;
                    BTN_COLOR = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3))
                                                            : 2'(mseq[mpos]);
                end
            end else if ($urandom_range(0, 7) == 0) begin
                BTN_VALID = 1'b1;
                BTN_COLOR = 2'($urandom_range(0, 3));
            end
        end
        @(negedge CLK);
        RESET = 1'b0; START = 1'b0; BTN_VALID = 1'b0;
        @(negedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
